// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_e     - arbiter FSM states (IDLE, BUSY_IF, BUSY_D, RESP)
//   BE_WORD         - full-word byte enable used for instruction fetches
//   TIMEOUT_DEFAULT - default watchdog limit in cycles; only used when the
//                     MEM_TIMEOUT_EN macro is defined
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam logic [3:0]  BE_WORD         = 4'b1111;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts cycles spent waiting for mem_ready and flags when
// the wait has lasted TIMEOUT cycles. Instantiated by mem_port_arbiter only
// when the MEM_TIMEOUT_EN macro is defined.
//   clk, reset  - clock, synchronous active-high reset
//   clear       - arbiter is entering a BUSY state this edge
//   busy        - arbiter is in a BUSY state
//   ready       - memory completion (mem_ready)
//   expired_c   - this edge is the TIMEOUT-th BUSY edge without mem_ready
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter restarts on each new grant and advances on every unanswered BUSY cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (busy && !ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that would take the count to TIMEOUT is the expiry edge;
    // a mem_ready on that same edge takes precedence.
    assign expired_c = busy && !ready && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// instruction fetch and the MEM stage. Fixed priority (data wins ties),
// req/ready handshake to memory, registered read data with one-cycle acks,
// and combinational stall signals for the pipeline registers.
// Optional feature: define MEM_TIMEOUT_EN to enable the mem_ready watchdog
// (sticky timeout_err, forced completion with zero read data).
//   Fetch port : if_req, if_addr -> if_rdata, if_ack
//   Data port  : d_req, d_we, d_be, d_addr, d_wdata -> d_rdata, d_ack
//   Memory     : mem_req, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata, mem_ready
//   Pipeline   : stall_if, stall_mem, timeout_err
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                timeout_err
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (TIMEOUT == 0) begin : g_timeout_check
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e        state_q,       state_d;
    logic              mem_req_q,     mem_req_d;
    logic              mem_we_q,      mem_we_d;
    logic [BE_W-1:0]   mem_be_q,      mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,     d_rdata_d;
    logic              if_ack_q,      if_ack_d;
    logic              d_ack_q,       d_ack_d;
    logic              timeout_err_q, timeout_err_d;
    logic              expired_c;

`ifdef MEM_TIMEOUT_EN
    logic wd_clear_c;
    logic wd_busy_c;

    // A grant happens on any IDLE edge with a pending request.
    assign wd_clear_c = (state_q == IDLE) && (d_req || if_req);
    assign wd_busy_c  = (state_q == BUSY_IF) || (state_q == BUSY_D);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (wd_clear_c),
        .busy      (wd_busy_c),
        .ready     (mem_ready),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    // Arbitration, memory handshake and response capture.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_be_d      = mem_be_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_req) begin
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = '1;
                    mem_addr_d = if_addr;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (expired_c) begin
                    state_d       = RESP;
                    mem_req_d     = 1'b0;
                    if_ack_d      = 1'b1;
                    if_rdata_d    = '0;
                    timeout_err_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    // Stores leave the load data register untouched.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (expired_c) begin
                    state_d       = RESP;
                    mem_req_d     = 1'b0;
                    d_ack_d       = 1'b1;
                    d_rdata_d     = '0;
                    timeout_err_d = 1'b1;
                end
            end
            RESP: begin
                // Ack cycle: no arbitration, requester drops its request now.
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign timeout_err = timeout_err_q;

    // Stalls follow the requests directly so the pipeline freezes in the same cycle.
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Each test pushes
// its expected transactions; a negedge monitor checks the memory-side request
// fields on each new mem_req and the returned data on each ack.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_be        (d_be),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          req_cycles;
    } exp_t;

    exp_t        sb[$];
    int          ack_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem_map [logic [31:0]];
    int          lat = 1;
    bit          hold_ready = 1'b0;
    int          rsp_cnt = 0;

    function automatic exp_t mk(input bit is_d, input bit we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int req_cycles);
        exp_t e;
        e.is_d = is_d; e.we = we; e.be = be; e.addr = addr;
        e.wdata = wdata; e.rdata = rdata; e.req_cycles = req_cycles;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (event did not occur as required)", name);
    endtask

    always @(posedge clk) cyc++;

    // Memory model: ready after 'lat' request cycles, or held high in hold mode.
    always @(negedge clk) begin
        if (reset) begin
            rsp_cnt   = 0;
            mem_ready = 1'b0;
        end else if (hold_ready) begin
            mem_ready = 1'b1;
        end else if (mem_req) begin
            rsp_cnt++;
            mem_ready = (rsp_cnt >= lat);
        end else begin
            rsp_cnt   = 0;
            mem_ready = 1'b0;
        end
        mem_rdata = mem_map.exists(mem_addr) ? mem_map[mem_addr] : 32'hDEAD_BEEF;
    end

    // Monitor: request fields on each new mem_req, response data on each ack.
    exp_t mon_e;
    int   req_cnt  = 0;
    bit   prev_req = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            req_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            if (mem_req) begin
                if (!prev_req) begin
                    if (sb.size() == 0) begin
                        fail("unexpected_mem_req");
                    end else begin
                        mon_e = sb[0];
                        chk("mem_addr", mem_addr, mon_e.addr);
                        chk("mem_we", 32'(mem_we), 32'(mon_e.we));
                        chk("mem_be", 32'(mem_be), 32'(mon_e.be));
                        if (mon_e.we) chk("mem_wdata", mem_wdata, mon_e.wdata);
                    end
                end
                req_cnt++;
            end
            if (if_ack || d_ack) begin
                if (if_ack && d_ack) fail("ack_overlap");
                if (sb.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_side_is_data", 32'(d_ack), 32'(mon_e.is_d));
                    if (mon_e.is_d) chk("d_rdata", d_rdata, mon_e.rdata);
                    else            chk("if_rdata", if_rdata, mon_e.rdata);
                    chk("mem_req_cycles", 32'(req_cnt), 32'(mon_e.req_cycles));
                    ack_log.push_back(cyc);
                end
                req_cnt = 0;
            end
            prev_req = mem_req;
        end
    end

    // Fetch requester: called at a negedge, holds if_req until if_ack.
    task automatic fetch(input logic [31:0] addr);
        int n;
        bit stall_checked;
        if_addr = addr;
        if_req  = 1'b1;
        n = 0;
        stall_checked = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (if_ack) break;
            if (!stall_checked) begin
                chk("stall_if_waiting", 32'(stall_if), 32'd1);
                stall_checked = 1'b1;
            end
            n++;
            if (n > 64) begin
                fail("if_ack_timeout");
                break;
            end
        end
        if (if_ack) chk("stall_if_at_ack", 32'(stall_if), 32'd0);
        @(negedge clk);
        if_req = 1'b0;
    endtask

    // Data requester: called at a negedge, holds d_req until d_ack.
    task automatic data_access(input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        bit stall_checked;
        d_we    = we;
        d_be    = be;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        n = 0;
        stall_checked = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (d_ack) break;
            if (!stall_checked) begin
                chk("stall_mem_waiting", 32'(stall_mem), 32'd1);
                stall_checked = 1'b1;
            end
            n++;
            if (n > 64) begin
                fail("d_ack_timeout");
                break;
            end
        end
        if (d_ack) chk("stall_mem_at_ack", 32'(stall_mem), 32'd0);
        @(negedge clk);
        d_req = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_req"},     32'(mem_req),     32'd0);
        chk({tag, "_mem_we"},      32'(mem_we),      32'd0);
        chk({tag, "_mem_be"},      32'(mem_be),      32'd0);
        chk({tag, "_mem_addr"},    mem_addr,         32'd0);
        chk({tag, "_mem_wdata"},   mem_wdata,        32'd0);
        chk({tag, "_if_rdata"},    if_rdata,         32'd0);
        chk({tag, "_d_rdata"},     d_rdata,          32'd0);
        chk({tag, "_if_ack"},      32'(if_ack),      32'd0);
        chk({tag, "_d_ack"},       32'(d_ack),       32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_stall_if"},    32'(stall_if),    32'd0);
        chk({tag, "_stall_mem"},   32'(stall_mem),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = '0;
        d_addr  = '0;
        d_wdata = '0;
        mem_map[32'h0000_0400] = 32'h8C01_0004;
        mem_map[32'h0000_0404] = 32'h0085_1020;
        mem_map[32'h0000_1000] = 32'h1234_5678;
        mem_map[32'h0000_3000] = 32'hCAFE_F00D;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk); #1 reset = 1'b0;

        // Fetch only, two-cycle memory latency.
        lat = 2;
        sb.push_back(mk(1'b0, 1'b0, BE_WORD, 32'h400, 32'h0, 32'h8C01_0004, 2));
        @(negedge clk);
        fetch(32'h400);
        repeat (2) @(negedge clk);

        // Simultaneous requests: data first, then fetch.
        lat = 1;
        sb.push_back(mk(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h1234_5678, 1));
        sb.push_back(mk(1'b0, 1'b0, BE_WORD, 32'h404, 32'h0, 32'h0085_1020, 1));
        @(negedge clk);
        fork
            fetch(32'h404);
            data_access(1'b0, 4'hF, 32'h1000, 32'h0);
        join
        repeat (2) @(negedge clk);

        // Partial store: d_rdata keeps the earlier load value.
        lat = 3;
        sb.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h2000, 32'hAABB_CCDD, 32'h1234_5678, 3));
        @(negedge clk);
        data_access(1'b1, 4'b0011, 32'h2000, 32'hAABB_CCDD);
        repeat (2) @(negedge clk);

        // mem_ready held: back-to-back loads keep the fetch waiting, one access per 3 cycles.
        hold_ready = 1'b1;
        ack_log.delete();
        sb.push_back(mk(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h1234_5678, 1));
        sb.push_back(mk(1'b1, 1'b0, 4'hF, 32'h3000, 32'h0, 32'hCAFE_F00D, 1));
        sb.push_back(mk(1'b0, 1'b0, BE_WORD, 32'h400, 32'h0, 32'h8C01_0004, 1));
        @(negedge clk);
        fork
            begin
                data_access(1'b0, 4'hF, 32'h1000, 32'h0);
                data_access(1'b0, 4'hF, 32'h3000, 32'h0);
            end
            fetch(32'h400);
        join
        repeat (2) @(negedge clk);
        chk("hold_ready_ack_count", 32'(ack_log.size()), 32'd3);
        if (ack_log.size() == 3) begin
            chk("hold_ready_gap_d_d", 32'(ack_log[1] - ack_log[0]), 32'd3);
            chk("hold_ready_gap_d_if", 32'(ack_log[2] - ack_log[1]), 32'd3);
        end
        hold_ready = 1'b0;
        repeat (2) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: forced completion after 4 request cycles.
        lat = 1000;
        sb.push_back(mk(1'b0, 1'b0, BE_WORD, 32'h404, 32'h0, 32'h0, 4));
        @(negedge clk);
        fetch(32'h404);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        lat = 1;
        sb.push_back(mk(1'b0, 1'b0, BE_WORD, 32'h400, 32'h0, 32'h8C01_0004, 1));
        @(negedge clk);
        fetch(32'h400);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        repeat (2) @(negedge clk);
`else
        // Memory never answers: the request waits indefinitely.
        lat = 1000;
        sb.push_back(mk(1'b0, 1'b0, BE_WORD, 32'h404, 32'h0, 32'h0, 0));
        @(negedge clk);
        if_addr = 32'h404;
        if_req  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_timeout_mem_req", 32'(mem_req), 32'd1);
        chk("no_timeout_if_ack", 32'(if_ack), 32'd0);
        chk("no_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk); #1;
        reset  = 1'b1;
        if_req = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk); #1 reset = 1'b0;
        lat = 1;
        repeat (2) @(negedge clk);
`endif

        // Reset in the middle of a data access.
        lat = 1000;
        sb.push_back(mk(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 0));
        @(negedge clk);
        d_we   = 1'b0;
        d_be   = 4'hF;
        d_addr = 32'h1000;
        d_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_d_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk); #1;
        reset = 1'b1;
        d_req = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("mid_reset");
        sb.delete();
        @(negedge clk); #1 reset = 1'b0;
        lat = 1;
        repeat (4) @(negedge clk);
        #1;
        chk("post_reset_d_ack", 32'(d_ack), 32'd0);
        chk("post_reset_mem_req", 32'(mem_req), 32'd0);
        chk("post_reset_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory between the instruction-fetch stage and the MEM stage of the five-stage MIPS pipeline. It arbitrates the two requesters with a fixed-priority FSM, drives a req/ready handshake to memory, returns registered read data with a one-cycle ack, and produces stall signals for the pipeline registers. It sits between the EX/MEM pipeline register outputs and the unified memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8)
- TIMEOUT, 255, max cycles to wait for mem_ready (used only with watchdog)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  registered fetch data
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  registered load data
- d_ack  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, held until mem_ready
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered copies of granted request
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  d_req & ~d_ack
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE: if d_req -> BUSY_D (data wins ties); else if if_req -> BUSY_IF; else stay. Granted request fields are latched into mem_* registers on the transition edge.
- BUSY_x: mem_req=1, mem_* stable. On an edge where mem_ready=1: capture mem_rdata into if_rdata (fetch) or d_rdata (loads only; stores leave d_rdata unchanged), then -> RESP.
- RESP: the granted requester's ack=1 for exactly this cycle; mem_req=0; no arbitration this cycle; -> IDLE.
- if_ack and d_ack are never high together; mem_req is low in IDLE and RESP.
- Reset values: state IDLE; mem_req, mem_we, if_ack, d_ack, timeout_err = 0; mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Reset mid-transaction: abandon it, no ack, mem_req low after the reset edge; the memory is reset by the same signal.

## Timing
- Request sampled at edge t (IDLE): mem_req high in cycle t+1.
- mem_ready sampled high at edge t+k (k>=1): ack high in cycle t+k+1; IDLE in t+k+2.
- Minimum access: 3 cycles from request to re-arbitration; a fetch pending during a data access is granted on the first IDLE edge with no d_req.
- stall_* are combinational from inputs and ack registers; no additional latency.

## Configuration
- MEM_TIMEOUT_EN defined: a counter clears on entry to BUSY_x and increments each BUSY cycle without mem_ready. When it reaches TIMEOUT, mem_req drops, rdata of the granted side is set to 0, the transition is -> RESP (ack delivered), and timeout_err is set and held until reset. mem_ready arriving on the same edge wins; that access is normal.
- Undefined: no counter; BUSY waits indefinitely; timeout_err is tied 0.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_D, RESP), BE_WORD=4'b1111, default TIMEOUT.
- One sub-module, mem_arb_watchdog (counter plus compare), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Fetch only, if_addr=0x400, ready after 2 cycles with rdata=0x8C010004 -> mem_req for 2 cycles, if_ack one cycle with if_rdata=0x8C010004, stall_if high until ack.
- Simultaneous if_req and d_req load at 0x1000 -> data granted first, d_ack, then fetch granted; acks never overlap.
- Store d_we=1, d_be=4'b0011, wdata=0xAABBCCDD -> mem_we=1, mem_be=0011, mem_wdata matches; d_rdata unchanged.
- mem_ready held at 1 -> exactly one access per 3 cycles and alternation only when d_req is low.
- Reset asserted in BUSY_D -> mem_req=0 and no d_ack after the edge; all outputs at reset values.
- MEM_TIMEOUT_EN, TIMEOUT=4, mem_ready never high -> mem_req for 4 cycles, ack with rdata=0, timeout_err=1 sticky; without the macro mem_req stays high.
